// File: rtl/addsub_pkg.sv
// addsub_pkg
//   Shared definitions for the add/subtract accumulator slice:
//   - op encodings (bit 1 selects accumulator as x, bit 0 selects subtract)
//   - flags_t: status flags that travel with every result
package addsub_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;  // a + b
    localparam logic [1:0] OP_SUB     = 2'b01;  // a - b
    localparam logic [1:0] OP_ACC_ADD = 2'b10;  // acc + a
    localparam logic [1:0] OP_ACC_SUB = 2'b11;  // acc - a

    typedef struct packed {
        logic overflow;  // signed overflow, before saturation
        logic carry;     // unsigned carry-out (subtract: 1 = no borrow)
        logic zero;      // final result == 0
        logic negative;  // final result MSB
    } flags_t;

    // Flag values the result register holds after reset (sum = 0).
    localparam flags_t FLAGS_RESET = '{overflow: 1'b0, carry: 1'b0, zero: 1'b1, negative: 1'b0};

endpackage

// File: rtl/addsub_core.sv
// addsub_core
//   Purely combinational WIDTH-bit two's complement adder/subtractor.
//   Computes x + (sub ? ~y : y) + sub, reports signed overflow and
//   unsigned carry, and optionally clamps signed overflow.
// Ports:
//   x, y     in   WIDTH  operands
//   sub      in   1      1 = x - y, 0 = x + y
//   result   out  WIDTH  final (possibly saturated) result
//   flags    out  flags_t overflow/carry/zero/negative of result
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   raw;
    logic             ovf;

    assign y_eff = sub ? ~y : y;
    // Extra top bit captures the unsigned carry-out; sub doubles as carry-in.
    assign raw   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    // Same-sign operands producing a different-sign sum is signed overflow.
    assign ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (raw[WIDTH-1] != x[WIDTH-1]);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
        result = raw[WIDTH-1:0];
        if (SATURATE && ovf) begin
            // Overflow direction follows the sign both operands shared.
            result = x[WIDTH-1] ? MAX_NEG : MAX_POS;
        end
    end

    assign flags.overflow = ovf;
    assign flags.carry    = raw[WIDTH];
    assign flags.zero     = (result == '0);
    assign flags.negative = result[WIDTH-1];

endmodule

// File: rtl/addsub_accum.sv
// addsub_accum
//   Registered add/subtract unit with internal accumulator, optional
//   saturation and sticky overflow, behind valid/ready handshakes.
//   One result register forms a single pipeline stage.
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   clr                  clears acc and ovf_sticky (blocks input that cycle)
//   in_valid/in_ready    operand handshake
//   a, b, op             operands and operation (see addsub_pkg)
//   out_valid/out_ready  result handshake
//   sum, overflow, carry, zero, negative   registered result and flags
//   ovf_sticky           OR of overflow over accepted ops since clr/reset
//   acc                  current accumulator value
module addsub_accum
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             ovf_sticky,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] result;
    flags_t           new_flags;
    flags_t           flags_q;
    logic             accept;

    // Accumulate modes take acc as x and a as y; b is ignored there.
    assign x = op[1] ? acc : a;
    assign y = op[1] ? a   : b;

    addsub_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .x      (x),
        .y      (y),
        .sub    (op[0]),
        .result (result),
        .flags  (new_flags)
    );

    // Handshake depends only on state, reset, clr and out_ready: never on operands.
    assign in_ready = !reset && !clr && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
        if (reset) begin
            out_valid  <= 1'b0;
            sum        <= '0;
            flags_q    <= FLAGS_RESET;
            acc        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            // clr and accept are exclusive because clr forces in_ready low.
            if (clr) begin
                acc        <= '0;
                ovf_sticky <= 1'b0;
            end
            if (accept) begin
                // Loading while draining keeps out_valid high: one result per cycle.
                out_valid  <= 1'b1;
                sum        <= result;
                flags_q    <= new_flags;
                acc        <= result;
                ovf_sticky <= ovf_sticky | new_flags.overflow;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign overflow = flags_q.overflow;
    assign carry    = flags_q.carry;
    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;

endmodule

// File: tb/tb_addsub_accum.sv
// Directed test of addsub_accum: one wrapping and one saturating instance
// share the same stimulus; expected values are hand-computed for WIDTH=8.
module tb_addsub_accum;
    import addsub_pkg::*;

    logic       clk = 1'b0;
    logic       reset, clr, in_valid, out_ready;
    logic [7:0] a, b;
    logic [1:0] op;

    logic       w_in_ready, w_out_valid, w_ovf, w_carry, w_zero, w_neg, w_sticky;
    logic [7:0] w_sum, w_acc;
    logic       s_in_ready, s_out_valid, s_ovf, s_carry, s_zero, s_neg, s_sticky;
    logic [7:0] s_sum, s_acc;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    addsub_accum #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .op(op), .out_valid(w_out_valid), .out_ready(out_ready),
        .sum(w_sum), .overflow(w_ovf), .carry(w_carry), .zero(w_zero), .negative(w_neg),
        .ovf_sticky(w_sticky), .acc(w_acc)
    );

    addsub_accum #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .op(op), .out_valid(s_out_valid), .out_ready(out_ready),
        .sum(s_sum), .overflow(s_ovf), .carry(s_carry), .zero(s_zero), .negative(s_neg),
        .ovf_sticky(s_sticky), .acc(s_acc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operation at the falling edge, hold it across the rising
    // edge, then return 1 time unit after that edge with in_valid low.
    task automatic apply(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        op = o; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Compare the wrapping instance's result register and flags.
    task automatic check_wrap(input string tag, input logic [7:0] s,
                              input logic ov, input logic cy, input logic z, input logic n);
        check({tag, ".sum"},      w_sum, s);
        check({tag, ".overflow"}, w_ovf, ov);
        check({tag, ".carry"},    w_carry, cy);
        check({tag, ".zero"},     w_zero, z);
        check({tag, ".negative"}, w_neg, n);
        check({tag, ".out_valid"}, w_out_valid, 1'b1);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = OP_ADD;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready_during", w_in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.in_ready",  w_in_ready, 1'b1);
        check("rst.out_valid", w_out_valid, 1'b0);
        check("rst.sum",       w_sum, 8'h00);
        check("rst.flags",     {w_ovf, w_carry, w_zero, w_neg}, 4'b0010);
        check("rst.sticky",    w_sticky, 1'b0);
        check("rst.acc",       w_acc, 8'h00);

        // ---- add / subtract ----
        apply(OP_ADD, 8'd13, 8'd12);
        check_wrap("add13_12", 8'd25, 1'b0, 1'b0, 1'b0, 1'b0);
        check("add13_12.acc", w_acc, 8'd25);
        apply(OP_SUB, 8'd13, 8'hF4);          // 13 - (-12)
        check_wrap("sub13_m12", 8'd25, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(OP_SUB, 8'hF3, 8'd12);          // -13 - 12
        check_wrap("subm13_12", 8'hE7, 1'b0, 1'b1, 1'b0, 1'b1);
        apply(OP_SUB, 8'd12, 8'd12);
        check_wrap("sub12_12", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        // ---- overflow, wrap vs saturate ----
        apply(OP_ADD, 8'd127, 8'd127);
        check_wrap("ovf_pos", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
        check("ovf_pos.sat_sum", s_sum, 8'h7F);
        check("ovf_pos.sat_ovf", s_ovf, 1'b1);
        check("ovf_pos.sat_neg", s_neg, 1'b0);
        apply(OP_ADD, 8'h81, 8'h81);          // -127 + -127
        check_wrap("ovf_neg", 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ovf_neg.sat_sum", s_sum, 8'h80);
        check("ovf_neg.sat_ovf", s_ovf, 1'b1);
        check("ovf_neg.sat_neg", s_neg, 1'b1);

        // ---- clr: blocks input, clears acc/sticky, keeps result register ----
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 8'd1; b = 8'd1;
        #1;
        check("clr.in_ready", w_in_ready, 1'b0);
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0;
        check("clr.acc",       w_acc, 8'h00);
        check("clr.sticky",    w_sticky, 1'b0);
        check("clr.sat_sticky", s_sticky, 1'b0);
        check("clr.sum_held",  w_sum, 8'h02);
        check("clr.out_valid", w_out_valid, 1'b0);

        // ---- accumulate ----
        apply(OP_ACC_ADD, 8'd100, 8'h00);
        check_wrap("acc100", 8'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        check("acc100.acc", w_acc, 8'd100);
        apply(OP_ACC_ADD, 8'd50, 8'h00);
        check_wrap("acc150", 8'h96, 1'b1, 1'b0, 1'b0, 1'b1);
        check("acc150.sticky", w_sticky, 1'b1);
        check("acc150.sat_sum", s_sum, 8'h7F);
        check("acc150.sat_sticky", s_sticky, 1'b1);
        apply(OP_ACC_SUB, 8'd6, 8'h00);
        check_wrap("accsub6", 8'h90, 1'b0, 1'b1, 1'b0, 1'b1);
        check("accsub6.acc", w_acc, 8'h90);
        check("accsub6.sticky", w_sticky, 1'b1);
        check("accsub6.sat_sum", s_sum, 8'd121);
        check("accsub6.sat_sticky", s_sticky, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr2.acc", w_acc, 8'h00);
        check("clr2.sticky", w_sticky, 1'b0);

        // ---- backpressure ----
        @(negedge clk);
        out_ready = 1'b0;
        apply(OP_ADD, 8'd3, 8'd4);
        check("bp.first", w_sum, 8'd7);
        @(negedge clk);
        op = OP_ADD; a = 8'd10; b = 8'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp.in_ready", w_in_ready, 1'b0);
            check("bp.sum_held", w_sum, 8'd7);
            check("bp.out_valid", w_out_valid, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", w_in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.new_sum", w_sum, 8'd11);
        check("bp.new_valid", w_out_valid, 1'b1);
        check("bp.acc", w_acc, 8'd11);
        @(posedge clk);
        #1;
        check("bp.drained", w_out_valid, 1'b0);
        check("bp.no_dup", w_acc, 8'd11);

        // ---- reset overrides pending result, clr and accept ----
        @(negedge clk);
        out_ready = 1'b0;
        apply(OP_ADD, 8'd5, 8'd5);
        check("rst2.pending", w_out_valid, 1'b1);
        @(negedge clk);
        reset = 1'b1; clr = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd1; op = OP_ADD;
        @(posedge clk);
        #1;
        check("rst2.out_valid", w_out_valid, 1'b0);
        check("rst2.sum",       w_sum, 8'h00);
        check("rst2.flags",     {w_ovf, w_carry, w_zero, w_neg}, 4'b0010);
        check("rst2.acc",       w_acc, 8'h00);
        check("rst2.sticky",    w_sticky, 1'b0);
        check("rst2.in_ready",  w_in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("rst2.in_ready_after", w_in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
